// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 4-deep byte FIFO feeding an 8N1 UART transmitter
module uart_tx_fifo #(
  parameter int CLK_DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy,
  output logic [2:0] fifo_count
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    count;
  state_t        state, state_n;
  logic [CW-1:0] bit_cnt, cnt_n;
  logic [7:0]    shreg, sh_n;
  logic [2:0]    idx, idx_n;
  logic          txd_q, txd_n;
  logic          push, pop;

  // tx_ready depends only on the registered count, never on tx_valid
  assign tx_ready   = (count < 3'd4);
  assign push       = tx_valid & tx_ready;
  assign fifo_count = count;
  assign txd        = txd_q;
  assign busy       = (state != IDLE) | (count != 3'd0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= 8'd0;
      idx     <= 3'd0;
      txd_q   <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= cnt_n;
      shreg   <= sh_n;
      idx     <= idx_n;
      txd_q   <= txd_n;
    end
  end

  // txd_n is the line level for the state being entered, so txd stays a pure register
  always_comb begin
    state_n = state;
    cnt_n   = bit_cnt;
    sh_n    = shreg;
    idx_n   = idx;
    txd_n   = txd_q;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        txd_n = 1'b1;
        if (count != 3'd0) begin
          pop     = 1'b1;
          sh_n    = mem[rd_ptr];
          cnt_n   = RELOAD;
          txd_n   = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (bit_cnt == '0) begin
          state_n = DATA;
          cnt_n   = RELOAD;
          idx_n   = 3'd0;
          txd_n   = shreg[0];
        end else begin
          cnt_n = bit_cnt - 1'b1;
        end
      end
      DATA: begin
        if (bit_cnt == '0) begin
          cnt_n = RELOAD;
          if (idx == 3'd7) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            sh_n  = {1'b0, shreg[7:1]};
            idx_n = idx + 3'd1;
            txd_n = shreg[1];
          end
        end else begin
          cnt_n = bit_cnt - 1'b1;
        end
      end
      STOP: begin
        if (bit_cnt == '0) begin
          // chain straight into the next START so queued frames have no idle gap
          if (count != 3'd0) begin
            pop     = 1'b1;
            sh_n    = mem[rd_ptr];
            cnt_n   = RELOAD;
            txd_n   = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end else begin
          cnt_n = bit_cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
  end

endmodule
